fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline. Owns the PC register, the instruction ROM and
//   the F/D pipeline register; computes next PC (PC+4 / beq / j,jal / jr) with one delay slot.
//   Feeds IRD to the D-stage controller; consumes enPC/enD from the stall controller.
// PARAMETERS
//   PC_RESET   32'h0000_3000  PC after reset; base address of the ROM
//   IM_WORDS   1024           ROM depth in 32-bit words
//   IM_FILE    "code.txt"     hex image loaded with $readmemh at time 0
// PORTS
//   clk       in   1   single clock, rising edge
//   reset_n   in   1   asynchronous, active-low reset
//   enPC      in   1   1: PC register may update; 0: hold (stall)
//   enD       in   1   1: F/D register may update; 0: hold (stall)
//   NPCSel    in   2   redirect request for the instruction in D: 00 seq, 01 beq, 10 j/jal, 11 jr
//   BrTaken   in   1   beq compare result from D (forwarded operands); used only when NPCSel=01
//   RSD       in   32  forwarded GPR[rs] of the D instruction; jr target
//   PCF       out  32  current fetch PC (debug)
//   IRD       out  32  instruction in D
//   PCD       out  32  PC of IRD
//   PC8D      out  32  PCD+8 (jal link value)
//   FetchErrD out  1   IRD was fetched from a misaligned or out-of-range PC
// BEHAVIOUR
//   Reset (async, reset_n=0): PCF=PC_RESET; IRD=0 (nop); PCD=0; PC8D=0; FetchErrD=0.
//     Takes effect immediately, mid-cycle included; all state releases on the first edge after reset_n=1.
//   Fetch: ROM read is combinational; idx = (PCF-PC_RESET)[31:2].
//     fetch_err = PCF[1:0]!=0 | PCF<PC_RESET | idx>=IM_WORDS; on fetch_err the fetched word is 32'h0.
//   Next PC, from PCF and the F/D register contents (PCD, IRD):
//     NPCSel=00, or 01 with BrTaken=0: PCF+4
//     01 with BrTaken=1: PCD+4 + {{14{IRD[15]}},IRD[15:0],2'b00}
//     10: {PCD_plus4[31:28], IRD[25:0], 2'b00}
//     11: RSD, loaded unmodified (no alignment masking)
//   Delay slot: at the edge a redirect is applied, the word at the old PCF (= PCD+4) still enters D. No squash.
//   Edge update: if enPC, PCF<=NPC. If enD, IRD<=fetched word; PCD<=PCF; PC8D<=PCF+8; FetchErrD<=fetch_err.
//   Stall (enPC=0): PCF holds and any redirect is ignored that cycle. It is re-evaluated next cycle,
//     since D is also held.
//   enPC=1,enD=0 or enPC=0,enD=1: honoured independently. The stall controller never issues these;
//     no protection is added.
//   Arithmetic: all adds are 32-bit modulo; PCF+4 wraps 0xFFFF_FFFC -> 0x0000_0000 and then sets fetch_err.
//   FetchErrD is not sticky; it travels with its instruction only.
//   Latency: instruction at PCF is visible on IRD one cycle after the edge that captures it.
// STRUCTURE
//   Shared header mips_defs.vh: NPC_SEQ/NPC_BEQ/NPC_J/NPC_JR encodings, PC_RESET default, NOP=32'h0.
//     The D controller uses the same header to drive NPCSel.
//   Sub-module im_rom (IM_WORDS, IM_FILE): combinational word read plus range check, outputs {instr, oob}.
//   Top contains the PC register, the NPC mux and the F/D register.
// TESTING
//   1 Reset: drive reset_n=0 mid-cycle while PCF=0x3010 -> PCF=0x3000, IRD=0, FetchErrD=0 before next edge.
//   2 Sequential: ROM[0..3]=A,B,C,D, NPCSel=00, enables=1 -> IRD=A,B,C,D on successive cycles;
//     PCD=0x3000.., PC8D=PCD+8.
//   3 beq taken: IRD=0x1000_0003 at PCD=0x3004, NPCSel=01, BrTaken=1 -> IRD=word@0x3008 (delay slot),
//     PCF=0x3014, then IRD=word@0x3014. With BrTaken=0 -> PCF=0x300C.
//   4 jal: IRD=0x0C00_0C10 at PCD=0x3000, NPCSel=10 -> PCF=0x0000_3040; PC8D for the jal was 0x3008.
//   5 Stall: enPC=enD=0 for 2 cycles with NPCSel=11, RSD=0x3100 -> PCF, IRD, PCD unchanged;
//     after release PCF=0x3100.
//   6 Fault: jr with RSD=0x3002, and separately PCF=0x3000+4*IM_WORDS -> next IRD=0, FetchErrD=1;
//     the following valid fetch clears FetchErrD.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage and the D-stage controller that drives the redirect select.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NpcSeq = 2'b00,
    NpcBeq = 2'b01,
    NpcJ   = 2'b10,
    NpcJr  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PcResetDefault = 32'h0000_3000;
  localparam logic [31:0] Nop            = 32'h0000_0000;

  // beq immediate -> byte offset relative to PCD+4
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_im_rom.sv
// Instruction ROM: combinational word read with misalignment and address-range checking.
module fetch_stage_im_rom #(
  parameter logic [31:0]             PC_RESET = 32'h0000_3000,
  parameter int unsigned             IM_WORDS = 1024,
  parameter logic [IM_WORDS*32-1:0]  IM_INIT  = '0
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_instr,
  output logic        o_oob
);
  import fetch_stage_pkg::*;

  localparam int unsigned IdxW     = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
  localparam logic [29:0] IdxLimit = 30'(IM_WORDS);

  logic [29:0]     w_idx;
  logic [IdxW-1:0] w_word_idx;
  logic [31:0]     w_word;

  // ROM base is word aligned, so the word index is a difference of word addresses
  assign w_idx      = i_addr[31:2] - PC_RESET[31:2];
  assign w_word_idx = w_idx[IdxW-1:0];
  assign w_word     = IM_INIT[{w_word_idx, 5'b00000} +: 32];

  assign o_oob   = (i_addr[1:0] != 2'b00) || (i_addr < PC_RESET) || (w_idx >= IdxLimit);
  assign o_instr = o_oob ? Nop : w_word;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection with one delay slot, and the F/D pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0]            PC_RESET = PcResetDefault,
  parameter int unsigned            IM_WORDS = 1024,
  parameter logic [IM_WORDS*32-1:0] IM_INIT  = '0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en_pc,
  input  logic        i_en_d,
  input  logic [1:0]  i_npc_sel,
  input  logic        i_br_taken,
  input  logic [31:0] i_rs_d,
  output logic [31:0] o_pc_f,
  output logic [31:0] o_ir_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc8_d,
  output logic        o_fetch_err_d
);

  logic [31:0] r_pc_f;
  logic [31:0] r_ir_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc8_d;
  logic        r_fetch_err_d;

  logic [31:0] w_instr_f;
  logic        w_fetch_err_f;
  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_pc_d_plus4;
  logic [31:0] w_npc;

  fetch_stage_im_rom #(
    .PC_RESET (PC_RESET),
    .IM_WORDS (IM_WORDS),
    .IM_INIT  (IM_INIT)
  ) u_im_rom (
    .i_addr  (r_pc_f),
    .o_instr (w_instr_f),
    .o_oob   (w_fetch_err_f)
  );

  assign w_pc_f_plus4 = r_pc_f + 32'd4;
  assign w_pc_d_plus4 = r_pc_d + 32'd4;

  // Redirects are computed from the instruction in D; the word at PCF is its delay slot
  always_comb begin
    w_npc = w_pc_f_plus4;
    unique case (npc_sel_e'(i_npc_sel))
      NpcSeq: w_npc = w_pc_f_plus4;
      NpcBeq: w_npc = i_br_taken ? (w_pc_d_plus4 + br_offset(r_ir_d[15:0])) : w_pc_f_plus4;
      NpcJ:   w_npc = {w_pc_d_plus4[31:28], r_ir_d[25:0], 2'b00};
      NpcJr:  w_npc = i_rs_d;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_f        <= PC_RESET;
      r_ir_d        <= Nop;
      r_pc_d        <= 32'h0;
      r_pc8_d       <= 32'h0;
      r_fetch_err_d <= 1'b0;
    end else begin
      if (i_en_pc) begin
        r_pc_f <= w_npc;
      end
      if (i_en_d) begin
        r_ir_d        <= w_instr_f;
        r_pc_d        <= r_pc_f;
        r_pc8_d       <= r_pc_f + 32'd8;
        r_fetch_err_d <= w_fetch_err_f;
      end
    end
  end

  assign o_pc_f        = r_pc_f;
  assign o_ir_d        = r_ir_d;
  assign o_pc_d        = r_pc_d;
  assign o_pc8_d       = r_pc8_d;
  assign o_fetch_err_d = r_fetch_err_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, async reset, beq, jal, stall and fetch faults.
module tb_fetch_stage;

  localparam int unsigned Words = 1024;

  function automatic logic [Words*32-1:0] build_rom();
    logic [Words*32-1:0] img;
    img = '0;
    img[32*0    +: 32] = 32'h0C00_0C10;  // jal 0x3040
    img[32*1    +: 32] = 32'h1000_0003;  // beq offset 3
    img[32*2    +: 32] = 32'h2222_2222;
    img[32*3    +: 32] = 32'h3333_3333;
    img[32*4    +: 32] = 32'h4444_4444;
    img[32*5    +: 32] = 32'h5555_5555;
    img[32*16   +: 32] = 32'h4040_4040;
    img[32*64   +: 32] = 32'h3100_3100;
    img[32*1023 +: 32] = 32'hFFFF_0001;
    return img;
  endfunction

  localparam logic [Words*32-1:0] RomImg = build_rom();

  logic        clk;
  logic        rst_n;
  logic        en_pc;
  logic        en_d;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] rs_d;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        fetch_err_d;

  int unsigned n_tests;
  int unsigned n_fail;

  fetch_stage #(
    .PC_RESET (32'h0000_3000),
    .IM_WORDS (Words),
    .IM_INIT  (RomImg)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en_pc       (en_pc),
    .i_en_d        (en_d),
    .i_npc_sel     (npc_sel),
    .i_br_taken    (br_taken),
    .i_rs_d        (rs_d),
    .o_pc_f        (pc_f),
    .o_ir_d        (ir_d),
    .o_pc_d        (pc_d),
    .o_pc8_d       (pc8_d),
    .o_fetch_err_d (fetch_err_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] sel, input logic br, input logic [31:0] rs);
    en_pc    = en;
    en_d     = en;
    npc_sel  = sel;
    br_taken = br;
    rs_d     = rs;
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    #1;
    do_reset();
    check("rst_pcf", pc_f, 32'h3000);
    check("rst_ird", ir_d, 32'h0);
    check("rst_err", {31'h0, fetch_err_d}, 32'h0);

    // sequential fetch
    step();
    check("seq0_ird", ir_d, 32'h0C00_0C10);
    check("seq0_pcd", pc_d, 32'h3000);
    check("seq0_pc8", pc8_d, 32'h3008);
    step();
    check("seq1_ird", ir_d, 32'h1000_0003);
    check("seq1_pcd", pc_d, 32'h3004);
    step();
    check("seq2_ird", ir_d, 32'h2222_2222);
    step();
    check("seq3_ird", ir_d, 32'h3333_3333);
    check("seq3_pc8", pc8_d, 32'h3014);
    check("seq3_pcf", pc_f, 32'h3010);

    // async reset asserted mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pcf", pc_f, 32'h3000);
    check("arst_ird", ir_d, 32'h0);
    check("arst_pcd", pc_d, 32'h0);
    check("arst_pc8", pc8_d, 32'h0);
    check("arst_err", {31'h0, fetch_err_d}, 32'h0);
    rst_n = 1'b1;

    // beq taken: delay slot at 0x3008 then target 0x3014
    step();
    step();
    check("beq_ird", ir_d, 32'h1000_0003);
    drive(1'b1, 2'b01, 1'b1, 32'h0);
    step();
    check("beq_pcf", pc_f, 32'h3014);
    check("beq_slot", ir_d, 32'h2222_2222);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    step();
    check("beq_tgt", ir_d, 32'h5555_5555);
    check("beq_tpcd", pc_d, 32'h3014);

    // beq not taken
    do_reset();
    step();
    step();
    drive(1'b1, 2'b01, 1'b0, 32'h0);
    step();
    check("bnt_pcf", pc_f, 32'h300C);
    drive(1'b1, 2'b00, 1'b0, 32'h0);

    // jal at 0x3000 -> 0x3040
    do_reset();
    step();
    check("jal_pc8", pc8_d, 32'h3008);
    drive(1'b1, 2'b10, 1'b0, 32'h0);
    step();
    check("jal_pcf", pc_f, 32'h3040);
    check("jal_slot", ir_d, 32'h1000_0003);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    step();
    check("jal_tgt", ir_d, 32'h4040_4040);
    check("jal_tpcd", pc_d, 32'h3040);

    // stall with pending jr
    drive(1'b0, 2'b11, 1'b0, 32'h3100);
    step();
    step();
    check("stl_pcf", pc_f, 32'h3044);
    check("stl_ird", ir_d, 32'h4040_4040);
    check("stl_pcd", pc_d, 32'h3040);
    drive(1'b1, 2'b11, 1'b0, 32'h3100);
    step();
    check("stl_rel", pc_f, 32'h3100);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    step();
    check("stl_tgt", ir_d, 32'h3100_3100);

    // misaligned jr target
    drive(1'b1, 2'b11, 1'b0, 32'h3002);
    step();
    check("mis_pcf", pc_f, 32'h3002);
    drive(1'b1, 2'b11, 1'b0, 32'h3000);
    step();
    check("mis_ird", ir_d, 32'h0);
    check("mis_err", {31'h0, fetch_err_d}, 32'h1);
    check("mis_pcd", pc_d, 32'h3002);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    step();
    check("mis_clr", {31'h0, fetch_err_d}, 32'h0);
    check("mis_nxt", ir_d, 32'h0C00_0C10);

    // one past the last ROM word
    drive(1'b1, 2'b11, 1'b0, 32'h4000);
    step();
    drive(1'b1, 2'b11, 1'b0, 32'h3004);
    step();
    check("oob_ird", ir_d, 32'h0);
    check("oob_err", {31'h0, fetch_err_d}, 32'h1);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    step();
    check("oob_clr", {31'h0, fetch_err_d}, 32'h0);
    check("oob_nxt", ir_d, 32'h1000_0003);

    // last valid word, then one word below the ROM base
    drive(1'b1, 2'b11, 1'b0, 32'h3FFC);
    step();
    drive(1'b1, 2'b11, 1'b0, 32'h2FFC);
    step();
    check("top_ird", ir_d, 32'hFFFF_0001);
    check("top_err", {31'h0, fetch_err_d}, 32'h0);
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    step();
    check("low_err", {31'h0, fetch_err_d}, 32'h1);
    check("low_ird", ir_d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
